// File: rtl/lfsr_scheduler_if.sv
// Request/grant and serial-output bundle shared by the seed producers, the
// LFSR scheduler and the serial consumer.
interface lfsr_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] seed;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  OUT;
  logic                  Valid;
  logic [NREQ-1:0]       done;

  modport master (output req, seed, input gnt, busy, OUT, Valid, done);
  modport slave  (input req, seed, output gnt, busy, OUT, Valid, done);
endinterface

// File: rtl/lfsr_scheduler.sv
// Round-robin arbiter sharing one scrambling LFSR: per grant it loads the
// winner's seed, warms up, serialises OUT_BITS bits LSB-first and pulses done.
module lfsr_scheduler #(
  parameter int                   NREQ     = 4,
  parameter int                   WIDTH    = 4,
  parameter logic [WIDTH-1:0]     TAPS     = 4'b0111,
  parameter int                   WARMUP   = 8,
  parameter int                   OUT_BITS = 4
) (
  input  logic             CLK,
  input  logic             RST,
  lfsr_scheduler_if.slave  bus
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (WARMUP > OUT_BITS) ? WARMUP : OUT_BITS;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WARM  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_rr_ptr;
  logic [IW-1:0]    r_win;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_done;
  logic             r_busy;
  logic             r_out;
  logic             r_valid;

  logic             w_any;
  logic [IW-1:0]    w_win;
  logic [WIDTH-1:0] w_seed_raw;
  logic [WIDTH-1:0] w_seed;
  logic             w_fb;
  logic             w_held;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
    if (p == IW'(NREQ - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = p + IW'(1);
    end
  endfunction

  assign w_fb   = ^(r_lfsr & TAPS);
  assign w_held = |(bus.req & r_gnt);

  // Round-robin scan from r_rr_ptr upward, wrapping modulo NREQ.
  always_comb begin
    int            s;
    logic [IW-1:0] idx;
    w_any = 1'b0;
    w_win = '0;
    s     = 0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = int'(r_rr_ptr) + k;
      if (s >= NREQ) begin
        s = s - NREQ;
      end else begin
        s = s;
      end
      idx = IW'(s);
      if (!w_any && bus.req[idx]) begin
        w_any = 1'b1;
        w_win = idx;
      end else begin
        w_any = w_any;
      end
    end
  end

  // Winner's seed, with an all-zero seed forced to 1 so the LFSR cannot lock up.
  always_comb begin
    w_seed_raw = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_win == IW'(k)) begin
        w_seed_raw = bus.seed[k*WIDTH +: WIDTH];
      end else begin
        w_seed_raw = w_seed_raw;
      end
    end
    if (w_seed_raw == '0) begin
      w_seed = WIDTH'(1);
    end else begin
      w_seed = w_seed_raw;
    end
  end

  // Transaction sequencer; an abandoning requester forfeits its turn.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_lfsr   <= '0;
      r_cnt    <= '0;
      r_rr_ptr <= '0;
      r_win    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_out    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= NREQ'(1) << w_win;
            r_win   <= w_win;
            r_lfsr  <= w_seed;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_WARM;
          end
        end
        S_WARM, S_SHIFT: begin
          if (!w_held) begin
            r_gnt    <= '0;
            r_valid  <= 1'b0;
            r_out    <= 1'b0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_rr_ptr <= next_ptr(r_win);
            r_state  <= S_IDLE;
          end else if (r_state == S_WARM) begin
            r_lfsr <= {w_fb, r_lfsr[WIDTH-1:1]};
            if (r_cnt == CW'(WARMUP - 1)) begin
              r_cnt   <= '0;
              r_state <= S_SHIFT;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else begin
            r_out   <= r_lfsr[0];
            r_valid <= 1'b1;
            r_lfsr  <= r_lfsr >> 1;
            if (r_cnt == CW'(OUT_BITS - 1)) begin
              r_cnt   <= '0;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_DONE: begin
          r_valid  <= 1'b0;
          r_out    <= 1'b0;
          r_done   <= r_gnt;
          r_gnt    <= '0;
          r_busy   <= 1'b0;
          r_rr_ptr <= next_ptr(r_win);
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_valid <= 1'b0;
          r_out   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.done  = r_done;
  assign bus.busy  = r_busy;
  assign bus.OUT   = r_out;
  assign bus.Valid = r_valid;

endmodule

// File: doc/lfsr_scheduler.md
Name: lfsr_scheduler

Overview:
- Shares one 4-bit scrambling LFSR engine among NREQ requesters.
- Per grant, the block:
  - loads the winner's seed,
  - runs WARMUP free-running shifts,
  - serialises OUT_BITS bits LSB-first on OUT/Valid,
  - pulses a per-requester done.
- Sits between the key/seed producers and the serial consumer. It replaces the stand-alone LFSR's self-timed sequencing with an arbitrated, restartable controller.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, LFSR width.
- TAPS, 4'b0111, feedback mask: MSB_next = XOR of LFSR bits where TAPS=1.
- WARMUP, 8, shift cycles between seed load and first output bit (1..31).
- OUT_BITS, 4, serial bits emitted per grant (1..WIDTH).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- req  in  NREQ  request per requester; held high until done or abandon.
- seed  in  NREQ*WIDTH  requester i seed at [i*WIDTH +: WIDTH]; sampled only on grant.
- gnt  out  NREQ  one-hot grant, held for the whole transaction.
- busy  out  1  high in any state other than IDLE.
- OUT  out  1  serial data bit.
- Valid  out  1  OUT qualifier.
- done  out  NREQ  one-cycle completion pulse to the granted requester.

Behaviour:
- Reset (async, RST=0): state=IDLE, gnt=0, busy=0, OUT=0, Valid=0, done=0, LFSR=0, counter=0, rr_ptr=0.
- States:
  - IDLE→WARM: on the edge where any req=1.
    - Winner = first set req scanning from rr_ptr upward, wrapping modulo NREQ.
    - gnt<=onehot(winner); LFSR<=seed[winner]; counter<=0.
    - A zero seed is replaced by {WIDTH-1 zeros,1} (lockup avoidance).
  - WARM: each edge LFSR<={^(LFSR&TAPS), LFSR[WIDTH-1:1]}; counter++.
    - After WARMUP shifts → SHIFT, counter<=0.
  - SHIFT: each edge OUT<=LFSR[0]; Valid<=1; LFSR<=LFSR>>1 (zero fill); counter++.
    - After OUT_BITS bits → DONE.
  - DONE: one cycle.
    - Valid<=0, OUT<=0, done[winner]<=1.
    - gnt<=0; rr_ptr<=(winner+1) mod NREQ; →IDLE.
    - done is high only during the cycle after DONE is entered, then cleared.
- Latency: req seen at edge E0 → gnt at E0 → first Valid after edge E0+WARMUP+1 → Valid high OUT_BITS consecutive cycles → done one cycle later.
- Earliest re-grant is the edge after DONE (IDLE lasts ≥1 cycle).
- Abandon: granted req deasserted in WARM or SHIFT.
  - Next edge: gnt=0, Valid=0, OUT=0, no done pulse.
  - rr_ptr advances past the abandoner; →IDLE.
- req changes by non-granted requesters mid-transaction have no effect. seed is ignored except at grant.
- Fairness: rr_ptr rotation guarantees a requester holding req waits at most NREQ-1 transactions.
- Reset asserted mid-transaction: all outputs zero immediately (async). No done pulse; fresh arbitration from rr_ptr=0 after release.
- Counters are sized to hold max(WARMUP, OUT_BITS) without wrap.

Test Plan:
1. req=0001, seed0=4'b1000, defaults.
   - gnt=0001, busy=1.
   - 8 warm shifts reach LFSR=0100.
   - OUT/Valid stream 0,0,1,0 over 4 cycles.
   - done=0001 one cycle later, then IDLE.
2. req=1111 held, all seeds 4'b1000.
   - Grants in order 0001,0010,0100,1000,0001.
   - Each transaction emits 0,0,1,0.
   - Exactly one done bit per transaction, matching gnt.
3. req=0100, seed2=4'b0000.
   - Seed substituted with 0001; after 8 shifts LFSR=1000.
   - Output 0,0,0,1 (never all-zero/stuck).
4. req=0010 granted; drop req[1] on 2nd SHIFT cycle.
   - Next edge gnt=0, Valid=0, no done.
   - Pending req=0101 then granted to requester 2 (rr_ptr=2).
5. Assert RST low for 1 cycle during WARM with req=0001.
   - All outputs zero asynchronously.
   - After release, requester 0 is re-granted and completes with the full 0,0,1,0 stream.
6. req=0001 held continuously alongside req[3].
   - After requester 0's done, requester 3 is granted before requester 0 is re-granted.
